pipe_controller: RTL and testbench
==================================

# pipe_controller

Registered, parametrised successor to the combinational decode controller. It decodes the ID-stage opcode into the execute/memory/writeback control bundle and latches that bundle into the ID/EX control register. It also handles load-use hazards, branch flushes and a valid/ready issue handshake. Multi-cycle MUL/DIV/MOD operations hold off further issue for a configurable number of cycles, which the combinational version could not do. It sits between the instruction decode stage and the ID/EX pipeline register.

## Interface
Parameters:
- OP_W, default `OP_CODE_LEN: opcode width.
- CMD_W, default `EXE_CMD_LEN: EXE command width.
- MUL_CYCLES, default 2: execute latency of OP_MUL, in cycles, ≥1.
- DIV_CYCLES, default 8: execute latency of OP_DIV and OP_MOD, in cycles, ≥1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ID stage presents an instruction.
- opCode  in  OP_W  opcode of the presented instruction.
- hazard_detected  in  1  load-use hazard; forces a bubble.
- flush  in  1  taken branch in EX; kills the presented instruction.
- in_ready  out  1  combinational; instruction is accepted when in_valid && in_ready.
- busy  out  1  registered; multi-cycle wait in progress.
- out_valid  out  1  registered; ID/EX holds a real instruction.
- out_exe_cmd  out  CMD_W  registered EXE command.
- out_branch_command  out  4  registered branch command.
- out_branchEn, out_is_imm, out_is_str, out_is_ldr, out_is_cmp, out_wb_en, out_mem_r_en, out_mem_w_en  out  1 each  registered control flags.
- out_illegal  out  1  registered; accepted opcode not in the decode map.

## Operation
- Decode map, as a function of opcode:
  - ADD/SUB/MUL/DIV/MOD/AND/OR: exe_cmd = same opcode, wb_en = 1.
  - CMP: exe_cmd = SUB, is_cmp = 1.
  - MOVR: exe_cmd = ADD, wb_en = 1.
  - MOVI: exe_cmd = ADD, wb_en = 1, is_imm = 1.
  - LDR: exe_cmd = ADD, wb_en = 1, mem_r_en = 1, is_ldr = 1.
  - STR: exe_cmd = ADD, mem_w_en = 1, is_str = 1.
  - BEQ/JMP: exe_cmd = branch_command = opcode, branchEn = 1.
  - All flags not listed for an opcode are 0.
  - Any other opcode: whole bundle is 0 and illegal = 1.
- in_ready = (state == RUN) && !hazard_detected && !flush.
- Each cycle the output register loads exactly one of:
  - the decoded bundle with out_valid = 1, on accept;
  - an all-zero bubble with out_valid = 0 and out_illegal = 0, otherwise.
- A bubble never asserts wb_en, mem_w_en, mem_r_en or branchEn.
- State machine:
  - RUN: on accept of MUL with MUL_CYCLES > 1, load cnt = MUL_CYCLES-1 and go to WAIT. On accept of DIV/MOD with DIV_CYCLES > 1, load cnt = DIV_CYCLES-1 and go to WAIT. Otherwise stay in RUN.
  - WAIT: cnt decrements each cycle. When cnt == 1 at an edge, the next state is RUN. in_ready = 0 throughout WAIT.
  - busy = (state == WAIT).
- cnt width is $clog2(max(MUL_CYCLES, DIV_CYCLES)+1). cnt never wraps and never decrements below 1 while in WAIT.
- flush does not abort a WAIT; the in-flight multi-cycle op is older than the branch.
- Simultaneous hazard_detected and flush: bubble. flush dominates only in that the instruction is dropped, not held; the ID stage is responsible for re-presentation.

## Timing
- Reset (rst = 1 at an edge): state = RUN, cnt = 0, busy = 0, out_valid = 0, every out_* = 0. in_ready = 0 during the reset cycle. rst takes priority over accept, and over WAIT when asserted mid-operation.
- Decode latency is 1 cycle: the bundle for an instruction accepted at edge N is visible after edge N.
- Multi-cycle op accepted at edge N: in_ready = 0 for cycles N+1 through N+L-1, where L is that op's latency, and is high again in cycle N+L if there is no hazard or flush. Next possible accept is edge N+L.
- out_valid is high for exactly one cycle per accepted instruction. A multi-cycle op is followed by L-1 bubble cycles.
- in_ready is combinational from hazard_detected, flush and state only, never from opCode.

## Test plan
- Reset: with the bundle nonzero, assert rst for 1 cycle → next cycle all outputs 0, busy = 0, state RUN.
- Back-to-back ADD, LDR, STR, BEQ with in_valid = 1 → four consecutive out_valid pulses. LDR shows wb_en = mem_r_en = is_ldr = 1. STR shows mem_w_en = is_str = 1, wb_en = 0. BEQ shows branchEn = 1, branch_command = OP_BEQ.
- DIV with DIV_CYCLES = 8 accepted at edge 0 → in_ready low and busy high for 7 cycles. An ADD held on in_valid is accepted at edge 8, and out_valid shows exactly 7 bubbles in between.
- hazard_detected high for 2 cycles while MOVI is presented → 2 bubbles, then MOVI accepted with is_imm = 1 and wb_en = 1. flush during DIV WAIT → counter unaffected, release cycle unchanged.
- Undefined opcode accepted → out_valid = 1, out_illegal = 1, all other flags 0. rst asserted in WAIT with cnt = 5 → busy = 0 and in_ready = 1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/pipe_controller.sv
// pipe_controller: registered decode controller between ID and the ID/EX
// register. Decodes the presented opcode into the EX/MEM/WB control bundle,
// inserts bubbles for load-use hazards and branch flushes, and holds off
// issue while a multi-cycle MUL/DIV/MOD is executing.

`ifndef OP_CODE_LEN
`define OP_CODE_LEN 4
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif
`ifndef OP_ADD
`define OP_ADD  1
`define OP_SUB  2
`define OP_MUL  3
`define OP_DIV  4
`define OP_MOD  5
`define OP_AND  6
`define OP_OR   7
`define OP_CMP  8
`define OP_MOVR 9
`define OP_MOVI 10
`define OP_LDR  11
`define OP_STR  12
`define OP_BEQ  13
`define OP_JMP  14
`endif

// state  | meaning
// -------+--------------------------------------------------------------
// RUN    | issue allowed; one instruction may be accepted per cycle
// WAIT   | multi-cycle op executing; cnt counts down, issue blocked

module pipe_controller #(
    parameter int OP_W       = `OP_CODE_LEN,
    parameter int CMD_W      = `EXE_CMD_LEN,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  opCode,
    input  logic             hazard_detected,
    input  logic             flush,
    output logic             in_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [CMD_W-1:0] out_exe_cmd,
    output logic [3:0]       out_branch_command,
    output logic             out_branchEn,
    output logic             out_is_imm,
    output logic             out_is_str,
    output logic             out_is_ldr,
    output logic             out_is_cmp,
    output logic             out_wb_en,
    output logic             out_mem_r_en,
    output logic             out_mem_w_en,
    output logic             out_illegal
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [OP_W-1:0] OP_ADD_C  = OP_W'(`OP_ADD);
    localparam logic [OP_W-1:0] OP_SUB_C  = OP_W'(`OP_SUB);
    localparam logic [OP_W-1:0] OP_MUL_C  = OP_W'(`OP_MUL);
    localparam logic [OP_W-1:0] OP_DIV_C  = OP_W'(`OP_DIV);
    localparam logic [OP_W-1:0] OP_MOD_C  = OP_W'(`OP_MOD);
    localparam logic [OP_W-1:0] OP_AND_C  = OP_W'(`OP_AND);
    localparam logic [OP_W-1:0] OP_OR_C   = OP_W'(`OP_OR);
    localparam logic [OP_W-1:0] OP_CMP_C  = OP_W'(`OP_CMP);
    localparam logic [OP_W-1:0] OP_MOVR_C = OP_W'(`OP_MOVR);
    localparam logic [OP_W-1:0] OP_MOVI_C = OP_W'(`OP_MOVI);
    localparam logic [OP_W-1:0] OP_LDR_C  = OP_W'(`OP_LDR);
    localparam logic [OP_W-1:0] OP_STR_C  = OP_W'(`OP_STR);
    localparam logic [OP_W-1:0] OP_BEQ_C  = OP_W'(`OP_BEQ);
    localparam logic [OP_W-1:0] OP_JMP_C  = OP_W'(`OP_JMP);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [CMD_W-1:0] exe_cmd;
        logic [3:0]       branch_command;
        logic             branch_en;
        logic             is_imm;
        logic             is_str;
        logic             is_ldr;
        logic             is_cmp;
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
        logic             illegal;
    } ctrl_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    ctrl_t            dec;
    logic             accept;
    logic             is_mul;
    logic             is_divmod;

    // Issue handshake: only in RUN, and never while a hazard or flush is pending.
    always_comb begin
        in_ready = !rst && (state_q == ST_RUN) && !hazard_detected && !flush;
        accept   = in_valid && in_ready;
    end

    // Opcode decode into the control bundle; unknown opcodes flag illegal only.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        is_mul    = 1'b0;
        is_divmod = 1'b0;
        case (opCode)
            OP_ADD_C, OP_SUB_C, OP_AND_C, OP_OR_C: begin
                dec.exe_cmd = CMD_W'(opCode);
                dec.wb_en   = 1'b1;
            end
            OP_MUL_C: begin
                dec.exe_cmd = CMD_W'(opCode);
                dec.wb_en   = 1'b1;
                is_mul      = 1'b1;
            end
            OP_DIV_C, OP_MOD_C: begin
                dec.exe_cmd = CMD_W'(opCode);
                dec.wb_en   = 1'b1;
                is_divmod   = 1'b1;
            end
            OP_CMP_C: begin
                dec.exe_cmd = CMD_W'(OP_SUB_C);
                dec.is_cmp  = 1'b1;
            end
            OP_MOVR_C: begin
                dec.exe_cmd = CMD_W'(OP_ADD_C);
                dec.wb_en   = 1'b1;
            end
            OP_MOVI_C: begin
                dec.exe_cmd = CMD_W'(OP_ADD_C);
                dec.wb_en   = 1'b1;
                dec.is_imm  = 1'b1;
            end
            OP_LDR_C: begin
                dec.exe_cmd  = CMD_W'(OP_ADD_C);
                dec.wb_en    = 1'b1;
                dec.mem_r_en = 1'b1;
                dec.is_ldr   = 1'b1;
            end
            OP_STR_C: begin
                dec.exe_cmd  = CMD_W'(OP_ADD_C);
                dec.mem_w_en = 1'b1;
                dec.is_str   = 1'b1;
            end
            OP_BEQ_C, OP_JMP_C: begin
                dec.exe_cmd        = CMD_W'(opCode);
                dec.branch_command = 4'(opCode);
                dec.branch_en      = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Output register source: decoded bundle on accept, all-zero bubble otherwise.
    always_comb begin
        ctrl_d = '0;
        if (accept) begin
            ctrl_d = dec;
        end
    end

    // Next-state logic for the issue FSM and its latency down-counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (accept && is_mul && (MUL_CYCLES > 1)) begin
                    state_d = ST_WAIT;
                    cnt_d   = MUL_LOAD;
                end else if (accept && is_divmod && (DIV_CYCLES > 1)) begin
                    state_d = ST_WAIT;
                    cnt_d   = DIV_LOAD;
                end
            end
            ST_WAIT: begin
                // Terminal count of 1 releases issue; the counter parks at 0 in RUN.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and ID/EX control register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Registered outputs.
    always_comb begin
        busy               = (state_q == ST_WAIT);
        out_valid          = ctrl_q.valid;
        out_exe_cmd        = ctrl_q.exe_cmd;
        out_branch_command = ctrl_q.branch_command;
        out_branchEn       = ctrl_q.branch_en;
        out_is_imm         = ctrl_q.is_imm;
        out_is_str         = ctrl_q.is_str;
        out_is_ldr         = ctrl_q.is_ldr;
        out_is_cmp         = ctrl_q.is_cmp;
        out_wb_en          = ctrl_q.wb_en;
        out_mem_r_en       = ctrl_q.mem_r_en;
        out_mem_w_en       = ctrl_q.mem_w_en;
        out_illegal        = ctrl_q.illegal;
    end

endmodule

// File: tb/tb_pipe_controller.sv
// Testbench for pipe_controller: directed steps plus a randomized phase,
// checked against a cycle-level reference model of the issue rules.

`ifndef OP_CODE_LEN
`define OP_CODE_LEN 4
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif
`ifndef OP_ADD
`define OP_ADD  1
`define OP_SUB  2
`define OP_MUL  3
`define OP_DIV  4
`define OP_MOD  5
`define OP_AND  6
`define OP_OR   7
`define OP_CMP  8
`define OP_MOVR 9
`define OP_MOVI 10
`define OP_LDR  11
`define OP_STR  12
`define OP_BEQ  13
`define OP_JMP  14
`endif

module tb_pipe_controller;

    localparam int MULC = 2;
    localparam int DIVC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] opCode = 4'd0;
    logic       hazard_detected = 1'b0;
    logic       flush = 1'b0;
    logic       in_ready, busy, out_valid;
    logic [3:0] out_exe_cmd, out_branch_command;
    logic       out_branchEn, out_is_imm, out_is_str, out_is_ldr, out_is_cmp;
    logic       out_wb_en, out_mem_r_en, out_mem_w_en, out_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: number of cycles issue remains blocked, and expected outputs.
    int          blocked = 0;
    logic [17:0] exp_bundle = '0;

    pipe_controller #(
        .OP_W(4), .CMD_W(4), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opCode(opCode),
        .hazard_detected(hazard_detected), .flush(flush),
        .in_ready(in_ready), .busy(busy), .out_valid(out_valid),
        .out_exe_cmd(out_exe_cmd), .out_branch_command(out_branch_command),
        .out_branchEn(out_branchEn), .out_is_imm(out_is_imm),
        .out_is_str(out_is_str), .out_is_ldr(out_is_ldr),
        .out_is_cmp(out_is_cmp), .out_wb_en(out_wb_en),
        .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // {valid, exe[3:0], br[3:0], branchEn, imm, str, ldr, cmp, wb, mem_r, mem_w, illegal}
    function automatic logic [17:0] expect_decode(input int op);
        logic [3:0] exe = 4'd0, br = 4'd0;
        logic bre = 0, imm = 0, str = 0, ldr = 0, cmp = 0, wb = 0, mr = 0, mw = 0, ill = 0;
        if (op >= `OP_ADD && op <= `OP_OR) begin exe = 4'(op); wb = 1; end
        else if (op == `OP_CMP)  begin exe = 4'(`OP_SUB); cmp = 1; end
        else if (op == `OP_MOVR) begin exe = 4'(`OP_ADD); wb = 1; end
        else if (op == `OP_MOVI) begin exe = 4'(`OP_ADD); wb = 1; imm = 1; end
        else if (op == `OP_LDR)  begin exe = 4'(`OP_ADD); wb = 1; mr = 1; ldr = 1; end
        else if (op == `OP_STR)  begin exe = 4'(`OP_ADD); mw = 1; str = 1; end
        else if (op == `OP_BEQ || op == `OP_JMP) begin exe = 4'(op); br = 4'(op); bre = 1; end
        else ill = 1;
        return {1'b1, exe, br, bre, imm, str, ldr, cmp, wb, mr, mw, ill};
    endfunction

    function automatic int latency(input int op);
        if (op == `OP_MUL) return MULC;
        if (op == `OP_DIV || op == `OP_MOD) return DIVC;
        return 1;
    endfunction

    function automatic logic [17:0] observed();
        return {out_valid, out_exe_cmd, out_branch_command, out_branchEn, out_is_imm,
                out_is_str, out_is_ldr, out_is_cmp, out_wb_en, out_mem_r_en,
                out_mem_w_en, out_illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check handshake, advance model, check outputs.
    task automatic step(input logic v, input int op, input logic hz, input logic fl,
                        input logic r, input string tag);
        logic exp_ready;
        in_valid        = v;
        opCode          = 4'(op);
        hazard_detected = hz;
        flush           = fl;
        rst             = r;
        #2;
        exp_ready = !r && (blocked == 0) && !hz && !fl;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (r) begin
            blocked    = 0;
            exp_bundle = '0;
        end else if (v && exp_ready) begin
            exp_bundle = expect_decode(op);
            blocked    = latency(op) - 1;
        end else begin
            exp_bundle = '0;
            if (blocked > 0) blocked--;
        end
        #1;
        check({tag, ".bundle"}, 32'(observed()), 32'(exp_bundle));
        check({tag, ".busy"}, 32'(busy), 32'(blocked > 0));
    endtask

    initial begin
        int bubbles;
        int accepted;

        @(posedge clk); #1;
        step(0, 0, 0, 0, 1, "reset0");
        step(0, 0, 0, 0, 1, "reset1");

        // Back-to-back issue
        step(1, `OP_ADD, 0, 0, 0, "b2b.add");
        step(1, `OP_LDR, 0, 0, 0, "b2b.ldr");
        check("ldr.flags", 32'({out_wb_en, out_mem_r_en, out_is_ldr}), 32'h7);
        step(1, `OP_STR, 0, 0, 0, "b2b.str");
        check("str.flags", 32'({out_mem_w_en, out_is_str, out_wb_en}), 32'h6);
        step(1, `OP_BEQ, 0, 0, 0, "b2b.beq");
        check("beq.br", 32'({out_branchEn, out_branch_command}), 32'({1'b1, 4'(`OP_BEQ)}));

        // Reset with a nonzero bundle in the register
        step(0, 0, 0, 0, 1, "rst.nonzero");
        check("rst.allzero", 32'(observed()), 32'h0);

        // DIV followed by a held ADD: seven bubbles, then ADD
        step(1, `OP_DIV, 0, 0, 0, "div.issue");
        bubbles  = 0;
        accepted = 0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            step(1, `OP_ADD, 0, 0, 0, "div.hold");
            if (out_valid) accepted = 1; else bubbles++;
        end
        check("div.accepted", 32'(accepted), 32'd1);
        check("div.bubbles", 32'(bubbles), 32'(DIVC - 1));

        // Flush during DIV WAIT leaves the release cycle unchanged
        step(1, `OP_DIV, 0, 0, 0, "divfl.issue");
        bubbles  = 0;
        accepted = 0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            step(1, `OP_AND, 0, (i >= 1 && i <= 3), 0, "divfl.hold");
            if (out_valid) accepted = 1; else bubbles++;
        end
        check("divfl.accepted", 32'(accepted), 32'd1);
        check("divfl.bubbles", 32'(bubbles), 32'(DIVC - 1));

        // MUL stalls for one cycle
        step(1, `OP_MUL, 0, 0, 0, "mul.issue");
        step(1, `OP_OR, 0, 0, 0, "mul.wait");
        check("mul.bubble", 32'(out_valid), 32'd0);
        step(1, `OP_OR, 0, 0, 0, "mul.next");

        // Hazard for two cycles while MOVI presented
        step(1, `OP_MOVI, 1, 0, 0, "haz.0");
        step(1, `OP_MOVI, 1, 0, 0, "haz.1");
        step(1, `OP_MOVI, 0, 0, 0, "haz.movi");
        check("movi.flags", 32'({out_valid, out_is_imm, out_wb_en}), 32'h7);
        step(1, `OP_CMP, 1, 1, 0, "hazfl.both");
        step(1, `OP_CMP, 0, 0, 0, "cmp");

        // Illegal opcodes
        step(1, 0, 0, 0, 0, "ill.0");
        check("ill0.flags", 32'({out_valid, out_illegal}), 32'h3);
        step(1, 15, 0, 0, 0, "ill.15");

        // Reset during WAIT with cnt = 5
        step(1, `OP_MOD, 0, 0, 0, "rstw.issue");
        step(0, 0, 0, 0, 0, "rstw.w0");
        step(0, 0, 0, 0, 0, "rstw.w1");
        step(1, `OP_ADD, 0, 0, 1, "rstw.rst");
        check("rstw.busy", 32'(busy), 32'd0);
        step(0, 0, 0, 0, 0, "rstw.after");

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 49) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
